// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
// Latency: address in cycle N with a combinational hit -> inst_ID valid after edge N+1; 1 inst/cycle.
// Backpressure: stall holds PC and IF/ID; a miss inserts one bubble per miss cycle; redirect/halt flush.
//
// Ports: clk, rst_b (async active-low); stall/halted/redirect_valid/redirect_pc from the decode
// control unit; icache_req/icache_addr/icache_hit/icache_data to the instruction cache;
// inst_ID/pc_ID/pc_plus4_ID/valid_ID form the IF/ID register; fetch_count/miss_cycles are
// performance counters, present only when FETCH_PERF_CNT_EN is defined (otherwise tied to 0).
module fetch_stage (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        stall,
  input  logic        halted,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_hit,
  input  logic [31:0] icache_data,
  output logic [31:0] inst_ID,
  output logic [31:0] pc_ID,
  output logic [31:0] pc_plus4_ID,
  output logic        valid_ID,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_cycles
);

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h0000_0000;  // SLL r0,r0,0

  typedef enum logic [1:0] {FETCH, MISS, MISS_DROP, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pend_q, redir_pend_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_p4_id_q, pc_p4_id_d;
  logic        valid_q, valid_d;
  logic        load_inst;
  logic        load_bubble;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_word;
  logic        unused_redirect_lsbs;

  assign pc_plus4             = pc_q + 32'd4;  // wraps modulo 2^32
  assign redirect_word        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign icache_req  = rst_b && (state_q != HALT);
  assign icache_addr = {pc_q[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    load_inst    = 1'b0;
    load_bubble  = 1'b0;

    if (state_q == HALT) begin
      // Only reset leaves HALT.
    end else if (halted) begin
      load_bubble = 1'b1;
      state_d     = HALT;
    end else if (redirect_valid) begin
      // Flush happens regardless of stall.
      load_bubble = 1'b1;
      if (icache_hit) begin
        pc_d    = redirect_word;
        state_d = FETCH;
      end else begin
        // The outstanding request on the old PC must drain before the target
        // can be fetched; remember the newest target until then.
        redir_pend_d = redirect_word;
        state_d      = MISS_DROP;
      end
    end else begin
      case (state_q)
        FETCH, MISS: begin
          if (icache_hit) begin
            state_d = FETCH;
            if (!stall) begin
              load_inst = 1'b1;
              pc_d      = pc_plus4;
            end
          end else begin
            state_d     = MISS;
            load_bubble = !stall;
          end
        end
        MISS_DROP: begin
          if (icache_hit) begin
            pc_d        = redir_pend_q;
            state_d     = FETCH;
            load_bubble = 1'b1;
          end else begin
            load_bubble = !stall;
          end
        end
        default: state_d = HALT;
      endcase
    end

    inst_d     = inst_q;
    pc_id_d    = pc_id_q;
    pc_p4_id_d = pc_p4_id_q;
    valid_d    = valid_q;
    if (load_inst) begin
      inst_d     = icache_data;
      pc_id_d    = pc_q;
      pc_p4_id_d = pc_plus4;
      valid_d    = 1'b1;
    end else if (load_bubble) begin
      inst_d  = BUBBLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redir_pend_q <= 32'h0;
      inst_q       <= BUBBLE;
      pc_id_q      <= 32'h0;
      pc_p4_id_q   <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      inst_q       <= inst_d;
      pc_id_q      <= pc_id_d;
      pc_p4_id_q   <= pc_p4_id_d;
      valid_q      <= valid_d;
    end
  end

  assign inst_ID     = inst_q;
  assign pc_ID       = pc_id_q;
  assign pc_plus4_ID = pc_p4_id_q;
  assign valid_ID    = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] miss_cycles_q, miss_cycles_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'h0, load_inst};
    miss_cycles_d = miss_cycles_q + {31'h0, (state_q == MISS) || (state_q == MISS_DROP)};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_count_q <= 32'h0;
      miss_cycles_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      miss_cycles_q <= miss_cycles_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign miss_cycles = miss_cycles_q;
`else
  assign fetch_count = 32'h0;
  assign miss_cycles = 32'h0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. Owns the PC, issues word fetches to the instruction cache, absorbs cache-miss latency, and presents `inst_ID`/`pc_ID` to the decode-stage control unit. It obeys that unit's stall, redirect (branch/jump/JR) and halt (SYSCALL) outcomes.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `BUBBLE`, 32'h0000_0000, instruction word inserted on flush or miss; decodes as SLL r0,r0,0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode is stalled: hold IF/ID and hold PC.
- `halted`  in  1  SYSCALL in decode: stop fetching.
- `redirect_valid`  in  1  taken branch, jump or JR resolved in decode.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored.
- `icache_req`  out  1  fetch request, combinational from state.
- `icache_addr`  out  32  word address, always the current PC, bits [1:0] = 0.
- `icache_hit`  in  1  `icache_data` valid this cycle.
- `icache_data`  in  32  fetched instruction.
- `inst_ID`  out  32  IF/ID instruction word.
- `pc_ID`  out  32  PC of `inst_ID`.
- `pc_plus4_ID`  out  32  `pc_ID` + 4, used for link writes.
- `valid_ID`  out  1  1 = real instruction, 0 = bubble.
- `fetch_count`, `miss_cycles`  out  32 each  performance counters; see Configuration.

## Operation
- States: FETCH, MISS, MISS_DROP, HALT.
- `icache_req` = 1 in FETCH, MISS and MISS_DROP. It is 0 in HALT and while `rst_b` = 0.
- Event priority, highest first: `halted`, then `redirect_valid`, then hit/miss handling.
- `halted` in any state except HALT:
  - IF/ID loads BUBBLE with `valid_ID` = 0; PC holds.
  - Next state is HALT. Only reset leaves HALT.
- `redirect_valid`:
  - IF/ID loads BUBBLE. This happens even when `stall` = 1.
  - In FETCH or MISS with `icache_hit` = 1: PC <= {`redirect_pc`[31:2], 2'b00}; next state FETCH. The returned data is discarded.
  - In MISS with no hit: the target is latched into `redir_pend`; next state MISS_DROP.
  - In MISS_DROP: `redir_pend` is overwritten, so the newest redirect wins.
- FETCH, hit, no stall: IF/ID <= {`icache_data`, PC, PC+4, valid=1}; PC <= PC+4.
- FETCH, hit, stall: IF/ID and PC hold. The same address is refetched next cycle.
- FETCH, miss: next state MISS. IF/ID loads BUBBLE if `stall` = 0, otherwise it holds.
- MISS: the request stays on the same address.
  - On hit with no stall: load IF/ID, PC+4, go to FETCH.
  - On hit with stall: go to FETCH, IF/ID holds.
  - Each cycle without a hit and without a stall loads BUBBLE.
- MISS_DROP: the request stays on the old PC until `icache_hit`. Then the data is discarded, PC <= `redir_pend`, next state FETCH, and IF/ID loads BUBBLE.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: PC = RESET_PC, state = FETCH, `inst_ID` = BUBBLE, `pc_ID` = 0, `pc_plus4_ID` = 0, `valid_ID` = 0, `redir_pend` = 0, counters = 0.
- Reset asserted mid-miss or in HALT returns all state to reset values immediately, without a clock edge.
- Hit latency: the address is driven in cycle N with a combinational hit, and `inst_ID` is valid after edge N+1. Throughput is 1 instruction per cycle.
- Miss with hit in cycle N+k: k bubbles reach decode.
- Redirect asserted in cycle N: the bubble is in ID after edge N+1, and the target is fetched in cycle N+1 (no pending miss).
- The redirect penalty is exactly 1 bubble.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on each valid IF/ID load.
  - `miss_cycles` increments on each cycle spent in MISS or MISS_DROP.
  - Both wrap at 2^32.
- `FETCH_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset release, RESET_PC = 0, always hit, no stall -> fetches at 0x0, 0x4, 0x8; `inst_ID` follows the words one cycle later; `valid_ID` = 1 from the second cycle.
- Miss at 0x10 for 3 cycles, then hit -> 3 bubbles with `valid_ID` = 0; then `inst_ID` = word@0x10 with `pc_ID` = 0x10; `miss_cycles` = 3 when enabled.
- Redirect to 0x40 during a hit at 0x8 -> next `inst_ID` is BUBBLE; `icache_addr` = 0x40 the next cycle; word@0x8 never reaches ID.
- Miss at 0x20, redirect to 0x80 at miss cycle 1, hit at cycle 4 -> data for 0x20 is dropped; `icache_addr` = 0x80 after the hit; all of ID is BUBBLE meanwhile.
- `stall` = 1 for 2 cycles with hits -> `inst_ID`/`pc_ID` unchanged; `icache_addr` constant; resumes with PC+4 afterwards.
- `halted` = 1 while `redirect_valid` = 1 -> HALT entered, `icache_req` = 0 forever, PC unchanged; assert `rst_b` = 0 -> PC = RESET_PC.
